// File: rtl/pe2_writeback_if.sv
// PE2 result / coefficient-RAM write bundle.
//   Result side : in_valid, in_ready, PE2_out3, PE2_out4 (valid/ready beats)
//   RAM side    : wr_en, wr_ready, wr_addr, wr_data3, wr_data4
// Modports:
//   master - the environment: drives result beats and RAM acceptance
//   slave  - the writeback block: accepts beats and issues RAM writes
interface pe2_writeback_if #(
    parameter int ADDR_W = 7
) ();
    logic              in_valid;
    logic              in_ready;
    logic [23:0]       PE2_out3;
    logic [23:0]       PE2_out4;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data3;
    logic [23:0]       wr_data4;

    modport master (
        output in_valid, PE2_out3, PE2_out4, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data3, wr_data4
    );

    modport slave (
        input  in_valid, PE2_out3, PE2_out4, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data3, wr_data4
    );
endinterface

// File: rtl/pe2_writeback.sv
// pe2_writeback: receiving end of the PE2 result interface.
// Accepts result beats, applies the final conditional modular subtraction
// (two 12-bit Kyber lanes or one 24-bit Dilithium coefficient per word),
// buffers them in a small FIFO and writes them to the coefficient RAM at
// sequential (wrapping) addresses, honouring RAM back-pressure.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   start      pass start pulse, sampled only in IDLE
//   KD_mode    0=Kyber, 1=Dilithium, latched at start
//   base_addr  first write address, latched at start
//   num_words  beats in the pass (0..2^ADDR_W), latched at start
//   busy       high while the pass is running or draining
//   done       one-cycle pulse at the end of a pass
//   bus        result beats in / RAM writes out (slave modport)
module pe2_writeback #(
    parameter int ADDR_W     = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int KQ         = 3329,
    parameter int DQ         = 8380417
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              KD_mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    pe2_writeback_if.slave    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_reg;
    logic              kd_reg;
    logic [ADDR_W:0]   num_reg;
    logic [ADDR_W:0]   accepted_reg;
    logic [ADDR_W:0]   written_reg;
    logic [ADDR_W-1:0] addr_cnt_reg;     // base + written, wraps naturally
    logic              done_reg;

    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]    count_reg, count_next;
    logic [23:0]       mem3 [FIFO_DEPTH];
    logic [23:0]       mem4 [FIFO_DEPTH];

    logic [23:0]       wr_data3_reg, wr_data4_reg, wr_data3_next, wr_data4_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;

    logic              fifo_full, in_ready, wr_en, push, pop;
    logic [23:0]       in_word  [2];
    logic [23:0]       red_word [2];

    // ------------------------------------------------------------------
    // Reduction: inputs are in [0,2q), so one conditional subtract suffices.
    // ------------------------------------------------------------------
    assign in_word[0] = bus.PE2_out3;
    assign in_word[1] = bus.PE2_out4;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_reduce
            logic [11:0] lane_hi, lane_lo, lane_hi_r, lane_lo_r;
            logic [23:0] dil_r;
            assign lane_hi   = in_word[gi][23:12];
            assign lane_lo   = in_word[gi][11:0];
            assign lane_hi_r = (lane_hi >= 12'(KQ)) ? lane_hi - 12'(KQ) : lane_hi;
            assign lane_lo_r = (lane_lo >= 12'(KQ)) ? lane_lo - 12'(KQ) : lane_lo;
            assign dil_r     = (in_word[gi] >= 24'(DQ)) ? in_word[gi] - 24'(DQ) : in_word[gi];
            assign red_word[gi] = kd_reg ? dil_r : {lane_hi_r, lane_lo_r};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshakes. in_ready deliberately ignores a same-cycle pop.
    // ------------------------------------------------------------------
    assign fifo_full = (count_reg == FULL_COUNT);
    assign in_ready  = (state_reg == S_RUN) && !fifo_full && (accepted_reg < num_reg);
    assign wr_en     = ((state_reg == S_RUN) || (state_reg == S_DRAIN)) && (count_reg != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = wr_en && bus.wr_ready;

    assign busy         = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign done         = done_reg;
    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr_reg;
    assign bus.wr_data3 = wr_data3_reg;
    assign bus.wr_data4 = wr_data4_reg;

    assign rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // The write outputs are registered copies of the next FIFO head, so they
    // hold stable under back-pressure and keep their last value once the
    // FIFO runs empty. A beat pushed into an otherwise empty FIFO becomes the
    // head directly (bypassing the array read).
    always_comb begin
        wr_data3_next = wr_data3_reg;
        wr_data4_next = wr_data4_reg;
        wr_addr_next  = wr_addr_reg;
        if (count_next != '0) begin
            if (push && (count_next == ONE_COUNT)) begin
                wr_data3_next = red_word[0];
                wr_data4_next = red_word[1];
            end else begin
                wr_data3_next = mem3[rd_ptr_next];
                wr_data4_next = mem4[rd_ptr_next];
            end
            wr_addr_next = pop ? addr_cnt_reg + 1'b1 : addr_cnt_reg;
        end
    end

    // FIFO storage: no reset needed, occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem3[wr_ptr_reg] <= red_word[0];
            mem4[wr_ptr_reg] <= red_word[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            wr_data3_reg <= '0;
            wr_data4_reg <= '0;
            wr_addr_reg  <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            count_reg    <= count_next;
            wr_data3_reg <= wr_data3_next;
            wr_data4_reg <= wr_data4_next;
            wr_addr_reg  <= wr_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Pass controller.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            kd_reg       <= 1'b0;
            num_reg      <= '0;
            accepted_reg <= '0;
            written_reg  <= '0;
            addr_cnt_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        kd_reg       <= KD_mode;
                        num_reg      <= num_words;
                        accepted_reg <= '0;
                        written_reg  <= '0;
                        addr_cnt_reg <= base_addr;
                        state_reg    <= (num_words == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (push) begin
                        accepted_reg <= accepted_reg + 1'b1;
                    end
                    if (pop) begin
                        written_reg  <= written_reg + 1'b1;
                        addr_cnt_reg <= addr_cnt_reg + 1'b1;
                    end
                    if (push && ((accepted_reg + 1'b1) == num_reg)) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop) begin
                        written_reg  <= written_reg + 1'b1;
                        addr_cnt_reg <= addr_cnt_reg + 1'b1;
                        if ((written_reg + 1'b1) == num_reg) begin
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule
